seq_divider_32bit: RTL and testbench

//   Multi-cycle restoring divider that sequences one shared 32-bit ripple subtractor.
//   It computes one quotient bit per clock, so a divide takes 32 iterations.

---
 rtl/div_pkg.sv | 17 +
 rtl/subtractor_32bit.sv | 23 ++
 rtl/seq_divider_32bit.sv | 163 ++++++++++++++++
 tb/tb_seq_divider_32bit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divide unit.
// Used by seq_divider_32bit; signed mode is enabled with DIVIDER_SIGNED_EN.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/subtractor_32bit.sv
// 32-bit ripple-borrow subtractor: diff = a - b mod 2^32.
// borrow_out is set when a < b (unsigned).
module subtractor_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] diff,
  output logic        borrow_out
);

  logic bw;

  // Ripple the borrow from bit 0 upward, one full subtractor per bit.
  always_comb begin
    bw   = 1'b0;
    diff = '0;
    for (int i = 0; i < 32; i++) begin
      diff[i] = a[i] ^ b[i] ^ bw;
      bw      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
    end
    borrow_out = bw;
  end

endmodule

// File: rtl/seq_divider_32bit.sv
// Restoring divider, one quotient bit per clock via one shared subtractor.
// Define DIVIDER_SIGNED_EN for the signed_op port and the FIX sign-correction state.
module seq_divider_32bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIVIDER_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;

  logic [WIDTH-1:0] rem_sh;
  logic             msb_out;
  logic [WIDTH-1:0] sub_a;
  logic [WIDTH-1:0] sub_b;
  logic [WIDTH-1:0] sub_d;
  logic             sub_bw;
  logic             take;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

`ifdef DIVIDER_SIGNED_EN
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] rem_neg;
`endif

  assign rem_sh  = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign msb_out = rem[WIDTH-1];

`ifdef DIVIDER_SIGNED_EN
  // FIX borrows the subtractor to negate the quotient (0 - quo).
  assign sub_a   = (state == FIX) ? '0  : rem_sh;
  assign sub_b   = (state == FIX) ? quo : dvsr;
  assign rem_neg = ~rem + 1'b1;
  assign dvd_mag = (signed_op & dividend[WIDTH-1]) ?
                   (~dividend + 1'b1) : dividend;
  assign dvs_mag = (signed_op & divisor[WIDTH-1]) ?
                   (~divisor + 1'b1) : divisor;
`else
  assign sub_a   = rem_sh;
  assign sub_b   = dvsr;
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  subtractor_32bit u_sub (
    .a         (sub_a),
    .b         (sub_b),
    .diff      (sub_d),
    .borrow_out(sub_bw)
  );

  assign take   = msb_out | ~sub_bw;
  assign rem_nx = take ? sub_d : rem_sh;
  assign quo_nx = {quo[WIDTH-2:0], take};

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
`ifdef DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            count       <= '0;
            rem         <= '0;
            quo         <= dvd_mag;
            dvsr        <= dvs_mag;
            div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= signed_op & dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= DIV_ZERO_QUOT;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              ready <= 1'b0;
              busy  <= 1'b1;
            end
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        CALC: begin
          rem   <= rem_nx;
          quo   <= quo_nx;
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) begin
`ifdef DIVIDER_SIGNED_EN
            state <= FIX;
`else
            state     <= DONE;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= quo_nx;
            remainder <= rem_nx;
`endif
          end
        end
`ifdef DIVIDER_SIGNED_EN
        FIX: begin
          state     <= DONE;
          ready     <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b1;
          quotient  <= neg_q ? sub_d : quo;
          remainder <= neg_r ? rem_neg : rem;
        end
`endif
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_32bit.sv
// Directed self-checking bench for seq_divider_32bit.
// Signed vectors run when DIVIDER_SIGNED_EN is defined.
module tb_seq_divider_32bit;

`ifdef DIVIDER_SIGNED_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
`ifdef DIVIDER_SIGNED_EN
  logic        signed_op;
`endif
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_divider_32bit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef DIVIDER_SIGNED_EN
    .signed_op  (signed_op),
`endif
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Caller is #1 after an edge (or mid-low phase); start is taken on the next edge.
  task automatic run_op(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic sg,
                        input logic poke, input int elat,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic ez);
    int lat;
    dividend = a;
    divisor  = b;
`ifdef DIVIDER_SIGNED_EN
    signed_op = sg;
`else
    if (sg) $display("note: %s signed request ignored", tag);
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (elat > 0) chk({tag, ".busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      start = poke && (lat == 5);
      if (start) begin
        dividend = 32'd9;
        divisor  = 32'd3;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".lat"}, 32'(lat), 32'(elat));
    chk({tag, ".q"}, quotient, eq);
    chk({tag, ".r"}, remainder, er);
    chk({tag, ".dz"}, 32'(div_by_zero), 32'(ez));
    chk({tag, ".rdy"}, 32'(ready), 32'd1);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef DIVIDER_SIGNED_EN
    signed_op = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 32'(ready), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.q", quotient, 32'd0);
    chk("rst.r", remainder, 32'd0);
    chk("rst.dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("d100_7", 32'd100, 32'd7, 1'b0, 1'b0, LAT,
           32'd14, 32'd2, 1'b0);
    @(posedge clk);
    #1;
    chk("pulse.done", 32'(done), 32'd0);
    chk("hold.q", quotient, 32'd14);
    chk("hold.r", remainder, 32'd2);

    run_op("msb", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b0, LAT,
           32'd1, 32'h7FFF_FFFE, 1'b0);
    run_op("dz", 32'd5, 32'd0, 1'b0, 1'b0, 0,
           32'hFFFF_FFFF, 32'd5, 1'b1);
    run_op("small", 32'd7, 32'd100, 1'b0, 1'b0, LAT,
           32'd0, 32'd7, 1'b0);
    run_op("by1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, LAT,
           32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op("mid", 32'd123456789, 32'd10000, 1'b0, 1'b0, LAT,
           32'd12345, 32'd6789, 1'b0);

    run_op("poke", 32'd100, 32'd7, 1'b0, 1'b1, LAT,
           32'd14, 32'd2, 1'b0);
    run_op("b2b", 32'd9, 32'd3, 1'b0, 1'b0, LAT,
           32'd3, 32'd0, 1'b0);

`ifdef DIVIDER_SIGNED_EN
    run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, LAT,
           32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op("s_min", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, LAT,
           32'h8000_0000, 32'd0, 1'b0);
    run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, LAT,
           32'hFFFF_FFFD, 32'd1, 1'b0);
    run_op("s_dz", 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0, 0,
           32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
`endif

    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid.busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst.busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("arst.ready", 32'(ready), 32'd1);
    chk("arst.done", 32'(done), 32'd0);
    chk("arst.q", quotient, 32'd0);
    chk("arst.r", remainder, 32'd0);
    chk("arst.dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op("post", 32'd50, 32'd6, 1'b0, 1'b0, LAT,
           32'd8, 32'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
